// File: rtl/matvec_seq_ctrl.sv
// Sequencer for an N x N matrix-vector array: streams operands in (matrix then vector),
// waits the array latency, then streams the N results out under valid/ready flow control.
module matvec_seq_ctrl #(
    parameter int N   = 16,
    parameter int DW  = 8,
    parameter int LAT = 2,
    localparam int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          arr_we,
    output logic          arr_sel,
    output logic [AW-1:0] arr_row,
    output logic [AW-1:0] arr_col,
    output logic [DW-1:0] arr_wdata,
    output logic [AW-1:0] arr_res_idx,
    input  logic [DW-1:0] arr_res,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          done,
    output logic [2:0]    state_dbg
);

    // Handshakes: a beat moves on a cycle where valid and ready are both high;
    // valid-side data must hold while ready is low, and ready never waits on valid.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_WAIT   = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_t        state, state_nx;
    logic [AW-1:0] row, col, ridx;
    logic [3:0]    wcnt;
    logic          xfer;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = (state == S_LOAD_A) || (state == S_LOAD_B);
        xfer      = in_valid && in_ready;
        arr_we    = xfer;
        arr_wdata = in_data;
        arr_sel   = (state == S_LOAD_B);
        arr_row   = row;
        arr_col   = col;
        arr_res_idx = ridx;
        out_valid = (state == S_DRAIN);
        out_data  = out_valid ? arr_res : '0;
        out_last  = out_valid && (ridx == LAST);
        done      = (state == S_DONE);
        busy      = (state != S_IDLE);
        state_dbg = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_LOAD_A;
            S_LOAD_A: if (xfer && row == LAST && col == LAST) state_nx = S_LOAD_B;
            S_LOAD_B: if (xfer && col == LAST) state_nx = S_WAIT;
            S_WAIT:   if (wcnt == '0) state_nx = S_DRAIN;
            S_DRAIN:  if (out_ready && ridx == LAST) state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Counters wrap to zero at the end of each phase, so every phase starts at index 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            row  <= '0;
            col  <= '0;
            ridx <= '0;
            wcnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    row  <= '0;
                    col  <= '0;
                    ridx <= '0;
                end
                S_LOAD_A: begin
                    if (xfer) begin
                        if (col == LAST) begin
                            col <= '0;
                            row <= (row == LAST) ? '0 : row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_LOAD_B: begin
                    if (xfer) begin
                        col <= (col == LAST) ? '0 : col + 1'b1;
                        if (col == LAST) wcnt <= 4'(LAT - 1);
                    end
                end
                S_WAIT: begin
                    if (wcnt != '0) wcnt <= wcnt - 1'b1;
                end
                S_DRAIN: begin
                    if (out_ready) ridx <= (ridx == LAST) ? '0 : ridx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matvec_seq_ctrl.sv
// Bench for matvec_seq_ctrl: random matrix/vector jobs with stalls, ignored starts and an
// aborted job, checked against per-beat expectations derived from job progress counts.
module tb_matvec_seq_ctrl;

    localparam int N     = 16;
    localparam int DW    = 8;
    localparam int LAT   = 2;
    localparam int AW    = $clog2(N);
    localparam int TOTAL = N * N + N;

    logic          clk = 1'b0;
    logic          reset, start, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic          busy, in_ready, arr_we, arr_sel, out_valid, out_last, done;
    logic [AW-1:0] arr_row, arr_col, arr_res_idx;
    logic [DW-1:0] arr_wdata, arr_res, out_data;
    logic [2:0]    state_dbg;

    logic          l1_busy, l1_in_ready, l1_arr_we, l1_arr_sel, l1_out_valid, l1_out_last, l1_done;
    logic [AW-1:0] l1_arr_row, l1_arr_col, l1_arr_res_idx;
    logic [DW-1:0] l1_arr_wdata, l1_res, l1_out_data;
    logic [2:0]    l1_state_dbg;

    logic [DW-1:0] a_mem [N][N];
    logic [DW-1:0] v_mem [N];
    logic [DW-1:0] exp_q [$];
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    matvec_seq_ctrl #(.N(N), .DW(DW), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .arr_we(arr_we), .arr_sel(arr_sel), .arr_row(arr_row), .arr_col(arr_col),
        .arr_wdata(arr_wdata), .arr_res_idx(arr_res_idx), .arr_res(arr_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .done(done), .state_dbg(state_dbg)
    );

    // Second build with LAT=1 shares the stimulus; only its wait length is examined.
    assign l1_res = '0;
    matvec_seq_ctrl #(.N(N), .DW(DW), .LAT(1)) dut_l1 (
        .clk(clk), .reset(reset), .start(start), .busy(l1_busy),
        .in_valid(in_valid), .in_ready(l1_in_ready), .in_data(in_data),
        .arr_we(l1_arr_we), .arr_sel(l1_arr_sel), .arr_row(l1_arr_row), .arr_col(l1_arr_col),
        .arr_wdata(l1_arr_wdata), .arr_res_idx(l1_arr_res_idx), .arr_res(l1_res),
        .out_valid(l1_out_valid), .out_ready(out_ready), .out_data(l1_out_data),
        .out_last(l1_out_last), .done(l1_done), .state_dbg(l1_state_dbg)
    );

    // Array model: stores what the controller writes and returns row dot vector.
    always @(posedge clk) begin
        if (arr_we) begin
            if (arr_sel) v_mem[arr_col] <= arr_wdata;
            else         a_mem[arr_row][arr_col] <= arr_wdata;
        end
    end

    always_comb begin
        logic [DW-1:0]   acc;
        logic [2*DW-1:0] prod;
        acc  = '0;
        prod = '0;
        for (int k = 0; k < N; k++) begin
            prod = {{DW{1'b0}}, a_mem[arr_res_idx][k]} * {{DW{1'b0}}, v_mem[k]};
            acc  = acc + prod[DW-1:0];
        end
        arr_res = acc;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic run_job(input bit ident, input int in_stall_beat, input int in_stall_len,
                           input int out_stall_idx, input int out_stall_len,
                           input bit poke, input bit chk_len, input bit chk_l1);
        logic [DW-1:0]   a [N][N];
        logic [DW-1:0]   v [N];
        logic [DW-1:0]   beats [$];
        logic [DW-1:0]   acc;
        logic [2*DW-1:0] prod;
        int beat, drained, cyc, lw_cyc, in_hold, out_hold, l1_lw, l1_beats;
        bit exp_done, fin, hs, exp_ir, exp_ov, l1_seen;

        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            v[i] = ident ? DW'(i) : DW'($urandom_range(0, 255));
            for (int j = 0; j < N; j++)
                a[i][j] = ident ? DW'(i == j) : DW'($urandom_range(0, 255));
        end
        for (int i = 0; i < N; i++) begin
            acc = '0;
            for (int j = 0; j < N; j++) begin
                prod = {{DW{1'b0}}, a[i][j]} * {{DW{1'b0}}, v[j]};
                acc  = acc + prod[DW-1:0];
            end
            exp_q.push_back(acc);
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) beats.push_back(a[i][j]);
        for (int i = 0; i < N; i++) beats.push_back(v[i]);

        beat = 0; drained = 0; cyc = 0; lw_cyc = -100; l1_lw = -100; l1_beats = 0;
        in_hold = in_stall_len; out_hold = out_stall_len;
        exp_done = 0; fin = 0; l1_seen = 0;
        @(posedge clk); #1;
        while (!fin) begin
            start     = (cyc == 0) || (poke && cyc > 0 && (cyc == lw_cyc + 1 || cyc == lw_cyc + LAT + 1));
            in_valid  = (beat < TOTAL) && !(beat == in_stall_beat && in_hold > 0);
            in_data   = (beat < TOTAL) ? beats[beat] : '0;
            out_ready = !(drained == out_stall_idx && out_hold > 0);
            @(negedge clk);
            hs     = 0;
            exp_ir = (cyc >= 1) && (beat < TOTAL);
            check_eq("busy", busy, cyc >= 1);
            check_eq("in_ready", in_ready, exp_ir);
            check_eq("arr_we", arr_we, in_valid && exp_ir);
            if (in_valid && exp_ir) begin
                check_eq("arr_sel", arr_sel, beat >= N * N);
                check_eq("arr_row", arr_row, (beat < N * N) ? beat / N : 0);
                check_eq("arr_col", arr_col, (beat < N * N) ? beat % N : beat - N * N);
                check_eq("arr_wdata", arr_wdata, beats[beat]);
                beat++;
                if (beat == TOTAL) lw_cyc = cyc;
            end else if (!in_valid && beat == in_stall_beat && in_hold > 0) begin
                in_hold--;
            end
            exp_ov = (beat == TOTAL) && (cyc > lw_cyc + LAT) && (drained < N);
            check_eq("out_valid", out_valid, exp_ov);
            if (exp_ov) begin
                check_eq("res_idx", arr_res_idx, drained);
                check_eq("out_data", out_data, exp_q[0]);
                check_eq("out_last", out_last, drained == N - 1);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    drained++;
                    hs = 1;
                end else begin
                    out_hold--;
                end
            end else begin
                check_eq("out_last_idle", out_last, 1'b0);
            end
            check_eq("done", done, exp_done);
            if (exp_done && chk_len) check_eq("job_len", cyc, N * N + N + LAT + N + 1);
            if (chk_l1) begin
                if (l1_arr_we) begin
                    l1_beats++;
                    if (l1_beats == TOTAL) l1_lw = cyc;
                end
                if (l1_out_valid && !l1_seen) begin
                    l1_seen = 1;
                    check_eq("l1_wait", cyc - l1_lw, 2);
                end
            end
            if (exp_done || done) fin = 1;
            if (cyc > 3000) begin
                check_eq("job_timeout", done, 1'b1);
                fin = 1;
            end
            exp_done = hs && (drained == N);
            if (!fin) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 0;
        in_valid = 0;
        if (chk_l1) check_eq("l1_drained", l1_seen, 1'b1);
    endtask

    task automatic abort_test();
        @(posedge clk); #1;
        start = 1; in_valid = 1; in_data = 8'h5a; out_ready = 1;
        repeat (N * N + 4) begin
            @(posedge clk); #1;
            start = 0;
        end
        @(negedge clk);
        check_eq("abort_sel", arr_sel, 1'b1);
        check_eq("abort_idx", arr_col, 3);
        reset = 1;
        @(posedge clk); #1;
        start = 1;
        @(negedge clk);
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_in_ready", in_ready, 1'b0);
        check_eq("abort_we", arr_we, 1'b0);
        check_eq("abort_addr", {arr_row, arr_col, arr_res_idx}, '0);
        @(posedge clk); #1;
        reset = 0; start = 0; in_valid = 0;
        @(negedge clk);
        check_eq("start_in_reset", busy, 1'b0);
    endtask

    initial begin
        reset = 1; start = 1; in_valid = 1; in_data = '0; out_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_flags", {busy, in_ready, arr_we, out_valid, out_last, done}, '0);
        check_eq("rst_addr", {arr_row, arr_col, arr_res_idx}, '0);
        check_eq("rst_state", state_dbg, '0);
        check_eq("rst_l1", {l1_busy, l1_in_ready, l1_arr_we, l1_arr_sel, l1_out_valid, l1_out_last,
                            l1_done, l1_arr_row, l1_arr_col, l1_arr_res_idx, l1_arr_wdata,
                            l1_out_data, l1_state_dbg}, '0);
        @(posedge clk); #1;
        reset = 0; start = 0; in_valid = 0;
        @(negedge clk);
        check_eq("rst_start_ignored", busy, 1'b0);

        run_job(1'b1, -1, 0, -1, 0, 1'b0, 1'b1, 1'b1);
        run_job(1'b0, 5 * N + 7, 3, 9, 4, 1'b0, 1'b0, 1'b0);
        run_job(1'b0, -1, 0, -1, 0, 1'b1, 1'b1, 1'b0);
        run_job(1'b0, $urandom_range(0, TOTAL - 1), $urandom_range(1, 5),
                $urandom_range(0, N - 1), $urandom_range(1, 5), 1'b0, 1'b0, 1'b0);
        abort_test();
        run_job(1'b0, -1, 0, -1, 0, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/matvec_seq_ctrl.md
MATVEC_SEQ_CTRL -- requirements
Module: matvec_seq_ctrl

Interface
REQ-001 Parameter N, default 16: matrix dimension (N x N matrix, N-element vector).
REQ-002 Parameter DW, default 8: operand and result element width in bits.
REQ-003 Parameter LAT, default 2: array compute latency in clk cycles, from last operand write to valid results; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 start  input  1  single-cycle request to begin one matrix-vector job.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 in_valid / in_ready / in_data  input / output / DW  operand stream: matrix row-major first, then vector.
REQ-009 arr_we / arr_sel / arr_row / arr_col / arr_wdata  output / output / output / output / output, widths 1 / 1 / clog2(N) / clog2(N) / DW  operand write port to the array; arr_sel 0 = matrix, 1 = vector.
REQ-010 arr_res_idx  output  clog2(N)  result element index presented to the array.
REQ-011 arr_res  input  DW  array result for arr_res_idx, combinational from the array.
REQ-012 out_valid / out_ready / out_data / out_last  output / input / output / output, widths 1 / 1 / DW / 1  result stream.
REQ-013 done  output  1  one-cycle pulse at job completion.

Function
REQ-014 FSM states: IDLE, LOAD_A, LOAD_B, WAIT, DRAIN, DONE.
REQ-015 IDLE -> LOAD_A on start = 1; start in any other state is ignored.
REQ-016 in_ready = 1 only in LOAD_A and LOAD_B; a beat transfers when in_valid = 1 and in_ready = 1.
REQ-017 arr_we = transfer, combinational; arr_wdata = in_data.
REQ-018 LOAD_A: row/col counters start at 0,0; col increments per beat and wraps N-1 -> 0 with row increment; arr_sel = 0.
REQ-019 LOAD_A -> LOAD_B on the transfer at row = N-1, col = N-1.
REQ-020 LOAD_B: arr_sel = 1, arr_col = element index 0..N-1, arr_row = 0; -> WAIT on the transfer at index N-1.
REQ-021 WAIT: a counter loads LAT-1 on entry and decrements each cycle; -> DRAIN when it reaches 0, giving exactly LAT cycles in WAIT.
REQ-022 DRAIN: out_valid = 1; out_data = arr_res; arr_res_idx = drain index, starting at 0.
REQ-023 Drain index advances only when out_valid = 1 and out_ready = 1; out_data, out_last and the index hold stable while out_ready = 0.
REQ-024 out_last = 1 when drain index = N-1; DRAIN -> DONE on that handshake.
REQ-025 DONE lasts exactly one cycle with done = 1, then -> IDLE.
REQ-026 Stalls: in_valid low in LOAD states or out_ready low in DRAIN hold all counters and state indefinitely.
REQ-027 Idle outputs: in_ready, arr_we, out_valid, out_last and done are 0 outside their stated states.
REQ-028 Back-to-back jobs: a start asserted in the cycle after DONE is accepted.
REQ-029 Minimum job length with continuous valid/ready: N*N + N + LAT + N + 1 cycles from the start cycle to done, inclusive of the DONE cycle.

Reset
REQ-030 reset = 1 forces IDLE and clears all counters on the next rising edge, from any state including mid-LOAD or mid-DRAIN.
REQ-031 Values while in reset and directly after it: busy, in_ready, arr_we, out_valid, out_last and done = 0; arr_row, arr_col and arr_res_idx = 0.
REQ-032 A start that coincides with reset is ignored; an aborted job's partial operands are not flushed, and the next job overwrites them.

Verification
REQ-033 Identity run: N=16; load identity matrix, vector v[i] = i; model array returns A*v after LAT=2 -> out_data 0..15 in order, out_last on beat 15, done at cycle 16*16+16+2+16+1 after start.
REQ-034 Input backpressure: in_valid low for 3 cycles at row 5, col 7 -> no arr_we in those cycles; next write is row 5, col 7; beat count totals exactly 272.
REQ-035 Output backpressure: out_ready low for 4 cycles at drain index 9 -> out_data = res[9] held stable for 4 cycles, out_last stays 0, then index 10 follows.
REQ-036 Reset mid-job: reset asserted while in LOAD_B at index 3 -> next cycle busy = 0, in_ready = 0; a new start then begins at LOAD_A, row 0, col 0.
REQ-037 Ignored start: start pulsed in WAIT and again in DRAIN -> no state change and the job completes normally; start the cycle after done -> new job accepted.
REQ-038 LAT=1 build: continuous traffic -> exactly 1 WAIT cycle between the last vector write and out_valid rising.
